grid_write_arbiter: RTL and testbench
=====================================

GRID_WRITE_ARBITER -- requirements
Module: grid_write_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive granted cycles before forced handover when another request pends.
REQ-002 Parameter PROT_BASE, default 8'd240: start of the protected next-piece region (PROT_BASE..8'd255).
REQ-003 clk  input  1  single clock, all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req[2:0]  input  3  write-port requests; 0 = piece placer, 1 = piece mover, 2 = line clearer.
REQ-006 we_i[2:0]  input  3  per-requester write enable, valid only while the matching gnt is high.
REQ-007 addr_i0/addr_i1/addr_i2  input  8 each  per-requester grid address.
REQ-008 data_i0/data_i1/data_i2  input  8 each  per-requester write data.
REQ-009 gnt[2:0]  output  3  one-hot-or-zero grant, registered.
REQ-010 mem_we  output  1  grid memory write enable, registered.
REQ-011 mem_addr  output  8  grid memory address, registered.
REQ-012 mem_data  output  8  grid memory write data, registered.
REQ-013 prot_err  output  1  one-cycle pulse when a protected-region write is suppressed.

Function
REQ-014 States: IDLE (gnt = 0) and OWNED (exactly one gnt bit high); the state is held in a registered owner index plus a valid bit.
REQ-015 IDLE: if any req bit is high at a clock edge, the winner's gnt goes high on that edge; grant latency is 1 cycle from req.
REQ-016 OWNED: the owner keeps gnt while its req stays high and the hold limit is not hit.
REQ-017 Owner drops req: its gnt clears on the next edge, and on that same edge another pending requester is granted (zero-idle handover); otherwise the state returns to IDLE.
REQ-018 hold_cnt counts granted cycles of the current owner, saturates at MAX_HOLD, and clears on every grant change.
REQ-019 hold_cnt == MAX_HOLD with another req pending: owner gnt clears and the next winner is granted on the same edge; the preempted requester re-competes normally.
REQ-020 hold_cnt == MAX_HOLD with no other req pending: owner keeps gnt and hold_cnt stays saturated.
REQ-021 Each cycle, mem_we/mem_addr/mem_data register the owner's we_i/addr_i/data_i, giving a 1-cycle write latency.
REQ-022 No owner, or owner we_i low: mem_we = 0, and mem_addr/mem_data hold their previous values.
REQ-023 Owner 1 or 2 writing an address >= PROT_BASE: mem_we = 0 and prot_err pulses high for 1 cycle; requester 0 is never blocked.
REQ-024 Simultaneous new reqs are resolved by the configured policy (REQ-029/030); a req asserted in the same cycle as an owner release is eligible for that handover.

Reset
REQ-025 rst low at a clock edge: gnt = 0, mem_we = 0, mem_addr = 0, mem_data = 0, prot_err = 0, hold_cnt = 0, owner invalid, RR pointer = 0.
REQ-026 Reset mid-burst aborts the burst immediately; no memory write is issued on the reset edge.
REQ-027 First grant is possible on the first edge after rst returns high.

Configuration
REQ-028 Macro GRID_ARB_ROUND_ROBIN_EN selects the arbitration policy.
REQ-029 Defined: round-robin; search starts at (last owner + 1) mod 3, and the pointer updates on every grant.
REQ-030 Undefined: fixed priority 0 > 1 > 2, no pointer register; the hold limit still applies.

Structure
REQ-031 Shared package grid_pkg: requester index constants (REQ_PLACER = 0, REQ_MOVER = 1, REQ_CLEAR = 2), PROT_BASE, the state encoding and the grid address/data widths.
REQ-032 One sub-module, arb_pick3: combinational winner select, taking req, pointer and an exclude mask and returning a winner index and valid.

Verification
REQ-033 req = 3'b011 from IDLE -> gnt = 3'b001 one cycle later (either policy).
REQ-034 Requester 0 granted, we_i0 = 1, addr_i0 = 8'd245, data_i0 = 8'd3 -> next cycle mem_we = 1, mem_addr = 245, mem_data = 3, prot_err = 0.
REQ-035 Requester 1 granted, we_i1 = 1, addr_i1 = 8'd240 -> next cycle mem_we = 0, prot_err = 1 for exactly one cycle.
REQ-036 req = 3'b111 held, MAX_HOLD = 4, round-robin build -> gnt sequence 001 (4 cycles), 010 (4), 100 (4), 001.
REQ-037 Requester 2 owner, req2 drops while req0 = 1 -> next edge gnt = 3'b001, no IDLE cycle.
REQ-038 rst low during a burst with we_i = 1 -> gnt = 0 and mem_we = 0 on that edge, and all outputs zero.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared definitions for the grid write arbiter: requester indices, protected
// region base, arbiter state encoding, grid widths and small index helpers.
package grid_pkg;

  localparam int GRID_AW = 8;
  localparam int GRID_DW = 8;

  localparam logic [1:0] REQ_PLACER = 2'd0;
  localparam logic [1:0] REQ_MOVER  = 2'd1;
  localparam logic [1:0] REQ_CLEAR  = 2'd2;

  localparam logic [7:0] PROT_BASE = 8'd240;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // (a + b) mod 3 for requester indices
  function automatic logic [1:0] wrap3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end else begin
      s = s;
    end
    return s[1:0];
  endfunction

  function automatic logic [2:0] idx_onehot(input logic [1:0] i);
    logic [2:0] r;
    case (i)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/grid_write_arbiter_if.sv
// Requester-side and memory-side signals of the grid write arbiter.
interface grid_write_arbiter_if;
  import grid_pkg::*;

  logic [2:0]         req;
  logic [2:0]         we_i;
  logic [GRID_AW-1:0] addr_i0;
  logic [GRID_AW-1:0] addr_i1;
  logic [GRID_AW-1:0] addr_i2;
  logic [GRID_DW-1:0] data_i0;
  logic [GRID_DW-1:0] data_i1;
  logic [GRID_DW-1:0] data_i2;
  logic [2:0]         gnt;
  logic               mem_we;
  logic [GRID_AW-1:0] mem_addr;
  logic [GRID_DW-1:0] mem_data;
  logic               prot_err;

  modport master (
    output req, we_i, addr_i0, addr_i1, addr_i2, data_i0, data_i1, data_i2,
    input  gnt, mem_we, mem_addr, mem_data, prot_err
  );

  modport slave (
    input  req, we_i, addr_i0, addr_i1, addr_i2, data_i0, data_i1, data_i2,
    output gnt, mem_we, mem_addr, mem_data, prot_err
  );

endinterface

// File: rtl/grid_write_arbiter_pick3.sv
// arb_pick3: combinational winner select among three requesters, searching
// upward from i_ptr (mod 3) and skipping requesters set in i_excl.
module arb_pick3
  import grid_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  input  logic [2:0] i_excl,
  output logic [1:0] o_win,
  output logic       o_valid
);

  logic [2:0] w_elig;
  logic [1:0] w_idx;

  assign w_elig = i_req & ~i_excl;

  // Walk the search order backwards so the earliest eligible index wins last
  always_comb begin
    o_win   = REQ_PLACER;
    o_valid = 1'b0;
    w_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      w_idx = wrap3_add(i_ptr, 2'(k));
      if (w_elig[w_idx]) begin
        o_win   = w_idx;
        o_valid = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/grid_write_arbiter.sv
// Three-port grid write arbiter with hold limit and protected next-piece region.
// Define GRID_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority 0>1>2.
module grid_write_arbiter #(
  parameter int         MAX_HOLD  = 16,
  parameter logic [7:0] PROT_BASE = grid_pkg::PROT_BASE
) (
  input  logic                 clk,
  input  logic                 rst,
  grid_write_arbiter_if.slave  bus
);
  import grid_pkg::*;

  localparam int             HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

  arb_state_e          r_state;
  logic [1:0]          r_owner;
  logic [HW-1:0]       r_hold;
  logic [2:0]          r_gnt;
  logic                r_mem_we;
  logic [GRID_AW-1:0]  r_mem_addr;
  logic [GRID_DW-1:0]  r_mem_data;
  logic                r_prot_err;

  logic [2:0]          w_owner_oh;
  logic [2:0]          w_excl;
  logic                w_other;
  logic                w_keep;
  logic [1:0]          w_ptr;
  logic [1:0]          w_pick_win;
  logic                w_pick_valid;
  logic                w_wr;
  logic                w_prot;
  logic [GRID_AW-1:0]  w_addr;
  logic [GRID_DW-1:0]  w_data;

  assign w_owner_oh = idx_onehot(r_owner);

  // Keep/handover decision and the current owner's write-port mux
  always_comb begin
    w_excl  = 3'b000;
    w_other = |(bus.req & ~w_owner_oh);
    w_keep  = 1'b0;
    w_wr    = 1'b0;
    if (r_state == ST_OWNED) begin
      w_excl = w_owner_oh;
      w_keep = (|(bus.req & w_owner_oh)) && !((r_hold == HOLD_MAX) && w_other);
      w_wr   = |(bus.we_i & w_owner_oh);
    end else begin
      w_excl = 3'b000;
    end
    case (r_owner)
      REQ_PLACER: begin w_addr = bus.addr_i0; w_data = bus.data_i0; end
      REQ_MOVER:  begin w_addr = bus.addr_i1; w_data = bus.data_i1; end
      REQ_CLEAR:  begin w_addr = bus.addr_i2; w_data = bus.data_i2; end
      default:    begin w_addr = '0;          w_data = '0;          end
    endcase
    // The placer owns the next-piece region; nobody else may write it
    w_prot = w_wr && (r_owner != REQ_PLACER) && (w_addr >= PROT_BASE);
  end

`ifdef GRID_ARB_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic       w_new_grant;

  assign w_new_grant = !w_keep && w_pick_valid;

  // Round-robin pointer: search starts just after the most recent grantee
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= 2'd0;
    end else if (w_new_grant) begin
      r_ptr <= wrap3_add(w_pick_win, 2'd1);
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = 2'd0;
`endif

  arb_pick3 u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_ptr),
    .i_excl  (w_excl),
    .o_win   (w_pick_win),
    .o_valid (w_pick_valid)
  );

  // Ownership FSM, hold counter and registered memory write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= REQ_PLACER;
      r_hold     <= '0;
      r_gnt      <= 3'b000;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_prot_err <= 1'b0;
    end else begin
      if (w_keep) begin
        if (r_hold != HOLD_MAX) begin
          r_hold <= r_hold + HW'(1);
        end else begin
          r_hold <= r_hold;
        end
      end else if (w_pick_valid) begin
        r_state <= ST_OWNED;
        r_owner <= w_pick_win;
        r_hold  <= HW'(1);
        r_gnt   <= idx_onehot(w_pick_win);
      end else begin
        r_state <= ST_IDLE;
        r_owner <= REQ_PLACER;
        r_hold  <= '0;
        r_gnt   <= 3'b000;
      end
      r_mem_we   <= w_wr && !w_prot;
      r_prot_err <= w_prot;
      if (w_wr && !w_prot) begin
        r_mem_addr <= w_addr;
        r_mem_data <= w_data;
      end else begin
        r_mem_addr <= r_mem_addr;
        r_mem_data <= r_mem_data;
      end
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign bus.prot_err = r_prot_err;

endmodule

// File: tb/tb_grid_write_arbiter.sv
// Self-checking bench for grid_write_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural arbitration model.
module tb_grid_write_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] t_req;
  logic [2:0] t_we;
  logic [7:0] t_addr [3];
  logic [7:0] t_data [3];

  int n_chk  = 0;
  int n_pass = 0;

  // model state
  int         m_owner;
  int         m_hold;
  int         m_ptr;
  logic [2:0] m_gnt;
  logic       m_we;
  logic       m_prot;
  logic [7:0] m_addr;
  logic [7:0] m_data;

  grid_write_arbiter_if bus ();

  assign bus.req     = t_req;
  assign bus.we_i    = t_we;
  assign bus.addr_i0 = t_addr[0];
  assign bus.addr_i1 = t_addr[1];
  assign bus.addr_i2 = t_addr[2];
  assign bus.data_i0 = t_data[0];
  assign bus.data_i1 = t_data[1];
  assign bus.data_i2 = t_data[2];

  grid_write_arbiter #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_gnt   = 3'b000;
    m_we    = 1'b0;
    m_prot  = 1'b0;
    m_addr  = 8'd0;
    m_data  = 8'd0;
  endtask

  // One clock edge of the arbiter, from the current inputs and model state
  task automatic model_edge();
    bit any_other;
    int nxt;
    int c;
    if (!rst) begin
      model_reset();
    end else begin
      if (m_owner >= 0 && t_we[m_owner]) begin
        if (m_owner != 0 && t_addr[m_owner] >= 8'd240) begin
          m_we = 1'b0; m_prot = 1'b1;
        end else begin
          m_we = 1'b1; m_prot = 1'b0;
          m_addr = t_addr[m_owner];
          m_data = t_data[m_owner];
        end
      end else begin
        m_we = 1'b0; m_prot = 1'b0;
      end
      any_other = 0;
      for (int i = 0; i < 3; i++)
        if (i != m_owner && t_req[i]) any_other = 1;
      if (m_owner >= 0 && t_req[m_owner] && !(m_hold == MH && any_other)) begin
        if (m_hold < MH) m_hold++;
      end else begin
        nxt = -1;
        for (int k = 0; k < 3; k++) begin
`ifdef GRID_ARB_ROUND_ROBIN_EN
          c = (m_ptr + k) % 3;
`else
          c = k;
`endif
          if (nxt < 0 && c != m_owner && t_req[c]) nxt = c;
        end
        if (nxt >= 0) begin
          m_owner = nxt; m_hold = 1; m_ptr = (nxt + 1) % 3;
        end else begin
          m_owner = -1; m_hold = 0;
        end
      end
    end
    m_gnt = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {11'd0, bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_data, bus.prot_err},
                 {11'd0, m_gnt, m_we, m_addr, m_data, m_prot});
  endtask

  initial begin
    logic [2:0] exp_g;
    model_reset();
    rst   = 1'b0;
    t_req = 3'b000;
    t_we  = 3'b000;
    for (int i = 0; i < 3; i++) begin t_addr[i] = 8'd0; t_data[i] = 8'd0; end
    cyc();
    cyc();
    chk("reset_gnt",  {29'd0, bus.gnt}, 32'd0);
    chk("reset_we",   {31'd0, bus.mem_we}, 32'd0);
    chk("reset_prot", {31'd0, bus.prot_err}, 32'd0);

    // First grant one edge after reset release, lowest index wins
    rst = 1'b1;
    t_req = 3'b011;
    cyc();
    chk("first_gnt", {29'd0, bus.gnt}, 32'd1);

    // Placer may write into the protected region
    t_we[0] = 1'b1; t_addr[0] = 8'd245; t_data[0] = 8'd3;
    cyc();
    chk("placer_we",   {31'd0, bus.mem_we}, 32'd1);
    chk("placer_addr", {24'd0, bus.mem_addr}, 32'd245);
    chk("placer_data", {24'd0, bus.mem_data}, 32'd3);
    chk("placer_prot", {31'd0, bus.prot_err}, 32'd0);
    t_we = 3'b000;

    // Zero-idle handover to the mover, then a blocked protected write
    t_req = 3'b010;
    cyc();
    chk("handover_mover", {29'd0, bus.gnt}, 32'd2);
    t_we[1] = 1'b1; t_addr[1] = 8'd240; t_data[1] = 8'd7;
    cyc();
    chk("mover_prot_we",  {31'd0, bus.mem_we}, 32'd0);
    chk("mover_prot_err", {31'd0, bus.prot_err}, 32'd1);
    t_we = 3'b000;
    cyc();
    chk("prot_pulse_end", {31'd0, bus.prot_err}, 32'd0);

    // Hold-limit rotation with all three requesting, from a fresh reset
    t_req = 3'b000;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    t_req = 3'b111;
    for (int k = 0; k < 13; k++) begin
      cyc();
`ifdef GRID_ARB_ROUND_ROBIN_EN
      exp_g = (k < 4) ? 3'b001 : (k < 8) ? 3'b010 : (k < 12) ? 3'b100 : 3'b001;
`else
      exp_g = (k < 4) ? 3'b001 : (k < 8) ? 3'b010 : (k < 12) ? 3'b001 : 3'b010;
`endif
      chk($sformatf("hold_seq%0d", k), {29'd0, bus.gnt}, {29'd0, exp_g});
    end

    // Reset in the middle of a writing burst
    t_we = 3'b111;
    t_addr[0] = 8'd5;  t_data[0] = 8'd9;
    t_addr[1] = 8'd6;  t_data[1] = 8'd10;
    t_addr[2] = 8'd7;  t_data[2] = 8'd11;
    cyc();
    chk("burst_we", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b0;
    cyc();
    chk("rst_mid_gnt",  {29'd0, bus.gnt}, 32'd0);
    chk("rst_mid_out",  {14'd0, bus.mem_we, bus.mem_addr, bus.mem_data, bus.prot_err}, 32'd0);
    rst = 1'b1;
    t_we = 3'b000;

    // Clearer releases while placer waits: no idle gap
    t_req = 3'b100;
    cyc();
    chk("clear_owner", {29'd0, bus.gnt}, 32'd4);
    t_req = 3'b001;
    cyc();
    chk("clear_to_placer", {29'd0, bus.gnt}, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      t_req = 3'($urandom);
      t_we  = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        t_addr[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(230, 255)) : 8'($urandom);
        t_data[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
